// File: rtl/stat_display_scan.sv
// ----------------------------------------------------------------------------
// stat_display_scan
//
// Consumer end of the pet-status interface. Takes a snapshot of the five 3-bit
// stat values once per frame and time-multiplexes them onto a 5-digit,
// common-anode, active-low 7-segment display. Between digits, all anodes are
// switched off for a short guard interval so that no ghost image of the
// previous digit appears. A low-stat alarm is raised while any snapshot value
// is at or below LOW_THRESH.
//
// Scan sequence per frame: LOAD (1 cycle), then for each digit 0..4:
// SHOW (CLK_DIV cycles) followed by BLANK (GUARD cycles).
// Frame period = 1 + 5*(CLK_DIV+GUARD) cycles.
//
// Optional feature macro: STAT_BLINK_EN
//   When defined, a digit whose snapshot value is low stays dark during SHOW
//   whenever bit BLINK_BIT of the frame counter is 1, so low stats blink.
//   When undefined, every digit is lit in every SHOW and no frame counter exists.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous reset, active-high
//   foodValue    in   3  food stat, digit 0
//   sleepValue   in   3  sleep stat, digit 1
//   funValue     in   3  fun stat, digit 2
//   happyValue   in   3  happy stat, digit 3
//   healthValue  in   3  health stat, digit 4
//   an           out  5  anode enables, active-low; an[i] lights digit i
//   seg          out  7  segments {g,f,e,d,c,b,a}, active-low
//   frame_done   out  1  one-cycle pulse (the LOAD cycle) after a full scan
//   low_alarm    out  1  high while any snapshot stat <= LOW_THRESH
// ----------------------------------------------------------------------------
module stat_display_scan #(
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 16,
    parameter int LOW_THRESH = 2,
    parameter int BLINK_BIT  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] foodValue,
    input  logic [2:0] sleepValue,
    input  logic [2:0] funValue,
    input  logic [2:0] happyValue,
    input  logic [2:0] healthValue,
    output logic [4:0] an,
    output logic [6:0] seg,
    output logic       frame_done,
    output logic       low_alarm
);

    localparam int MAX_DWELL = (CLK_DIV > GUARD) ? CLK_DIV : GUARD;
    localparam int CNT_W     = $clog2(MAX_DWELL + 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scanState_t;

    scanState_t       state, stateNext;
    logic [2:0]       digit, digitNext;
    logic [CNT_W-1:0] dwellCnt, dwellNext;
    logic [4:0][2:0]  snap, snapNext;
    logic [4:0][2:0]  liveStats;
    logic [4:0]       anNext;
    logic [6:0]       segNext;
    logic             frameDoneNext;
    logic             lowAlarmNext;
    logic             showEn;
    logic [2:0]       showDigit;
    logic [2:0]       showVal;

`ifdef STAT_BLINK_EN
    localparam int FRAME_W = BLINK_BIT + 1;
    logic [FRAME_W-1:0] frameCnt, frameCntNext;
`endif

    function automatic logic [6:0] decodeDigit(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            default: s = 7'b1111000;
        endcase
        return s;
    endfunction

    function automatic logic isLow(input logic [2:0] v);
        return v <= 3'(LOW_THRESH);
    endfunction

    function automatic logic anyLow(input logic [4:0][2:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r = r | isLow(v[i]);
        end
        return r;
    endfunction

    // Live inputs packed so that element i is the stat shown on digit i.
    assign liveStats = {healthValue, happyValue, funValue, sleepValue, foodValue};

    // State register. Every output is a register loaded from the next-value
    // logic below, so the display pins never see combinational glitches.
    // Reset returns the scan to LOAD with the display dark and flags cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            digit      <= '0;
            dwellCnt   <= '0;
            snap       <= '0;
            an         <= 5'b11111;
            seg        <= 7'b1111111;
            frame_done <= 1'b0;
            low_alarm  <= 1'b0;
`ifdef STAT_BLINK_EN
            frameCnt   <= '0;
`endif
        end else begin
            state      <= stateNext;
            digit      <= digitNext;
            dwellCnt   <= dwellNext;
            snap       <= snapNext;
            an         <= anNext;
            seg        <= segNext;
            frame_done <= frameDoneNext;
            low_alarm  <= lowAlarmNext;
`ifdef STAT_BLINK_EN
            frameCnt   <= frameCntNext;
`endif
        end
    end

    // Next-state and next-output logic. LOAD takes the snapshot and starts
    // digit 0 in the same edge, using the live inputs since the snapshot
    // register is only being written on that edge. SHOW holds the digit for
    // CLK_DIV cycles and then blanks it; BLANK waits GUARD cycles and then
    // either lights the next digit or, after digit 4, returns to LOAD while
    // pulsing frame_done. The dwell counter restarts at every state change.
    // Lighting a digit is funnelled through showEn/showDigit/showVal so that
    // the optional blink suppression is applied in exactly one place.
    always_comb begin
        stateNext     = state;
        digitNext     = digit;
        dwellNext     = dwellCnt + CNT_W'(1);
        snapNext      = snap;
        anNext        = an;
        segNext       = seg;
        frameDoneNext = 1'b0;
        lowAlarmNext  = low_alarm;
        showEn        = 1'b0;
        showDigit     = '0;
        showVal       = '0;
`ifdef STAT_BLINK_EN
        frameCntNext  = frameCnt;
`endif

        case (state)
            LOAD: begin
                snapNext     = liveStats;
                lowAlarmNext = anyLow(liveStats);
                stateNext    = SHOW;
                digitNext    = '0;
                dwellNext    = '0;
                showEn       = 1'b1;
                showDigit    = 3'd0;
                showVal      = foodValue;
            end
            SHOW: begin
                if (dwellCnt == CNT_W'(CLK_DIV - 1)) begin
                    anNext    = 5'b11111;
                    segNext   = 7'b1111111;
                    stateNext = BLANK;
                    dwellNext = '0;
                end
            end
            BLANK: begin
                if (dwellCnt == CNT_W'(GUARD - 1)) begin
                    dwellNext = '0;
                    if (digit == 3'd4) begin
                        stateNext     = LOAD;
                        frameDoneNext = 1'b1;
`ifdef STAT_BLINK_EN
                        frameCntNext  = frameCnt + FRAME_W'(1);
`endif
                    end else begin
                        stateNext = SHOW;
                        digitNext = digit + 3'd1;
                        showEn    = 1'b1;
                        showDigit = digit + 3'd1;
                        showVal   = snap[digit + 3'd1];
                    end
                end
            end
            default: begin
                stateNext = LOAD;
                dwellNext = '0;
                anNext    = 5'b11111;
                segNext   = 7'b1111111;
            end
        endcase

        if (showEn) begin
            anNext  = ~(5'b00001 << showDigit);
            segNext = decodeDigit(showVal);
`ifdef STAT_BLINK_EN
            if (isLow(showVal) && frameCnt[BLINK_BIT]) begin
                anNext = 5'b11111;
            end
`endif
        end
    end

endmodule
